// File: rtl/bcd_seg_if.sv
// bcd_seg_if
//   Valid/ready handshake carrying one packed BCD word {tens[7:4], ones[3:0]}
//   from the binary-to-BCD converter to the 7-segment scanner.
//   Signals:
//     bcd_in     packed BCD word, meaningful only while bcd_valid is high
//     bcd_valid  producer has a word this cycle
//     bcd_ready  consumer can take a word this cycle
//   Modports:
//     master  producer side (drives bcd_in/bcd_valid, observes bcd_ready)
//     slave   consumer side (observes bcd_in/bcd_valid, drives bcd_ready)
interface bcd_seg_if;
  logic [7:0] bcd_in;
  logic       bcd_valid;
  logic       bcd_ready;

  modport master (
    output bcd_in,
    output bcd_valid,
    input  bcd_ready
  );

  modport slave (
    input  bcd_in,
    input  bcd_valid,
    output bcd_ready
  );
endinterface

// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner
//   Takes a packed BCD word {tens,ones} over a valid/ready handshake into a
//   pending buffer, copies it into the display buffer only at the end of a
//   full ones+tens scan frame (so a digit pair never tears), and time-
//   multiplexes the two digits onto a common-anode 7-segment bus. Words with
//   a nibble above 9 raise bcd_err and show a dash for the offending digit.
//   Ports:
//     clk      rising-edge clock
//     rst_n    asynchronous active-low reset (assert async, release sync)
//     bus      bcd_seg_if.slave: bcd_in, bcd_valid in; bcd_ready out
//     seg      segments {g,f,e,d,c,b,a}, registered, polarity per SEG_ACTIVE_LOW
//     an       digit enables, active-low; an[0] = ones, an[1] = tens, registered
//     bcd_err  displayed word holds a nibble > 9, registered
//   Parameters:
//     SCAN_DIV        cycles each digit stays lit (>= 2)
//     SEG_ACTIVE_LOW  1: seg active-low, 0: seg active-high
//   Build option:
//     LEADING_ZERO_BLANK_EN  when defined, a tens digit of 0 is left dark
//                            (anodes off, segments off) for its phase.
module bcd_seg_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  bcd_seg_if.slave      bus,
  output logic [6:0]    seg,
  output logic [1:0]    an,
  output logic          bcd_err
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  // Active-high gfedcba pattern; non-decimal nibbles render as a dash.
  function automatic logic [6:0] enc(input logic [3:0] nib);
    logic [6:0] p;
    case (nib)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1101111;
      default: p = 7'b1000000;
    endcase
    return p;
  endfunction

  function automatic logic [6:0] drive(input logic [6:0] p);
    return SEG_ACTIVE_LOW ? ~p : p;
  endfunction

  function automatic logic nib_bad(input logic [3:0] nib);
    return nib > 4'd9;
  endfunction

  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic             dsel_q, dsel_d;
  logic [7:0]       disp_q, disp_d;
  logic [7:0]       pend_q;
  logic             pend_full_q, pend_full_d;
  logic             err_q, err_d;
  logic [1:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic             wrap;
  logic             swap;
  logic             accept;
  logic             blank;
  logic [3:0]       digit;

  assign wrap   = (scan_cnt_q == CNT_LAST);
  // frame_end is a wrap while the tens digit is being shown.
  assign swap   = wrap & dsel_q & pend_full_q;
  assign accept = bus.bcd_valid & ~pend_full_q;

  assign bus.bcd_ready = ~pend_full_q;
  assign seg           = seg_q;
  assign an            = an_q;
  assign bcd_err       = err_q;

  assign digit = dsel_q ? disp_q[7:4] : disp_q[3:0];

`ifdef LEADING_ZERO_BLANK_EN
  assign blank = dsel_q & (disp_q[7:4] == 4'd0);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    scan_cnt_d  = wrap ? '0 : scan_cnt_q + 1'b1;
    dsel_d      = wrap ? ~dsel_q : dsel_q;
    pend_full_d = pend_full_q;
    disp_d      = disp_q;
    err_d       = err_q;

    // Accept and swap are mutually exclusive: one needs pend empty, the
    // other needs it full.
    if (swap) begin
      pend_full_d = 1'b0;
      disp_d      = pend_q;
      err_d       = nib_bad(pend_q[7:4]) | nib_bad(pend_q[3:0]);
    end else if (accept) begin
      pend_full_d = 1'b1;
    end

    // Output stage reflects the digit selected in the current cycle.
    if (blank) begin
      an_d  = 2'b11;
      seg_d = SEG_OFF;
    end else begin
      an_d  = dsel_q ? 2'b01 : 2'b10;
      seg_d = drive(enc(digit));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q  <= '0;
      dsel_q      <= 1'b0;
      disp_q      <= 8'h00;
      pend_full_q <= 1'b0;
      err_q       <= 1'b0;
      an_q        <= 2'b11;
      seg_q       <= SEG_OFF;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      dsel_q      <= dsel_d;
      disp_q      <= disp_d;
      pend_full_q <= pend_full_d;
      err_q       <= err_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  // Pending word payload is qualified by pend_full_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_q <= bus.bcd_in;
    end
  end

endmodule
